// File: rtl/wb_stage.sv
// Write-back stage: captures retiring instructions from IO, owns the 32xN register file,
// and drives the ID back-pass, debug trace and retired-instruction counter.
module wb_stage #(
   parameter int unsigned REG_COUNT  = 32,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                    clock,
   input  logic                    reset,
   output logic                    wb_allow_in,
   input  logic                    io_to_wb_valid,
   input  logic [31:0]             io_to_wb_program_count,
   input  logic [DATA_WIDTH-1:0]   io_to_wb_final_result,
   input  logic [4:0]              io_to_wb_rf_address,
   input  logic                    io_to_wb_rf_write_enabled,
   input  logic [DATA_WIDTH/8-1:0] io_to_wb_rf_write_strobe,
   input  logic [4:0]              read_address_0,
   input  logic [4:0]              read_address_1,
   output logic [DATA_WIDTH-1:0]   read_data_0,
   output logic [DATA_WIDTH-1:0]   read_data_1,
   output logic                    wb_to_id_valid,
   output logic [4:0]              wb_to_id_write_register,
   input  logic                    trace_stall,
   output logic [31:0]             debug_wb_pc,
   output logic [DATA_WIDTH/8-1:0] debug_wb_rf_wen,
   output logic [4:0]              debug_wb_rf_wnum,
   output logic [DATA_WIDTH-1:0]   debug_wb_rf_wdata,
   output logic [31:0]             retired_count
);

   localparam int unsigned LANES = DATA_WIDTH / 8;

   logic                  wb_valid;
   logic [31:0]           wb_pc;
   logic [DATA_WIDTH-1:0] wb_result;
   logic [4:0]            wb_addr;
   logic                  wb_we;
   logic [LANES-1:0]      wb_strobe;

   logic                  wb_ready_go;
   logic                  retire;
   logic                  rf_we;
   logic [DATA_WIDTH-1:0] wb_merged;

   logic [DATA_WIDTH-1:0] rf [REG_COUNT];

   assign wb_ready_go = ~trace_stall;
   assign wb_allow_in = ~wb_valid | wb_ready_go;
   assign retire      = wb_valid & wb_ready_go;
   assign rf_we       = retire & wb_we & (wb_addr != 5'd0);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wb_valid  <= 1'b0;
         wb_pc     <= '0;
         wb_result <= '0;
         wb_addr   <= '0;
         wb_we     <= 1'b0;
         wb_strobe <= '0;
      end else if (wb_allow_in) begin
         wb_valid <= io_to_wb_valid;
         if (io_to_wb_valid) begin
            wb_pc     <= io_to_wb_program_count;
            wb_result <= io_to_wb_final_result;
            wb_addr   <= io_to_wb_rf_address;
            wb_we     <= io_to_wb_rf_write_enabled;
            wb_strobe <= io_to_wb_rf_write_strobe;
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         retired_count <= '0;
      end else if (retire) begin
         retired_count <= retired_count + 32'd1;
      end
   end

   // Merged word serves both the register write and same-cycle write-through reads.
   always_comb begin
      wb_merged = rf[wb_addr];
      for (int unsigned i = 0; i < LANES; i++) begin
         if (wb_strobe[i]) begin
            wb_merged[8*i +: 8] = wb_result[8*i +: 8];
         end
      end
   end

   // Register file is intentionally unreset; entry 0 is never written and never read.
   always_ff @(posedge clock) begin
      if (rf_we) begin
         rf[wb_addr] <= wb_merged;
      end
   end

   always_comb begin
      read_data_0 = '0;
      read_data_1 = '0;
      if (read_address_0 != 5'd0) begin
         read_data_0 = (rf_we && read_address_0 == wb_addr) ? wb_merged : rf[read_address_0];
      end
      if (read_address_1 != 5'd0) begin
         read_data_1 = (rf_we && read_address_1 == wb_addr) ? wb_merged : rf[read_address_1];
      end
   end

   assign wb_to_id_valid          = wb_valid & wb_we & (wb_addr != 5'd0);
   assign wb_to_id_write_register = wb_addr;

   assign debug_wb_pc       = wb_pc;
   assign debug_wb_rf_wen   = {LANES{retire & wb_we}} & wb_strobe;
   assign debug_wb_rf_wnum  = wb_addr;
   assign debug_wb_rf_wdata = wb_result;

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Final (write-back) pipeline stage of the MIPS core. It accepts retiring instructions from the IO (memory-result) stage through the valid/allow-in handshake.
- It performs byte-strobed writes into the 32x32 architectural register file it owns and serves the two ID-stage read ports.
- It drives the back-pass bus to ID for hazard detection, the debug trace interface, and a retired-instruction counter.

Parameters:
- REG_COUNT, 32, number of GPRs; register 0 is hardwired to zero.
- DATA_WIDTH, 32, register/data width; must be a multiple of 8.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- wb_allow_in  out  1  stage can accept an IO-stage instruction this cycle.
- io_to_wb_valid  in  1  IO stage presents a valid instruction.
- io_to_wb_program_count  in  32  PC of the incoming instruction.
- io_to_wb_final_result  in  32  result data.
- io_to_wb_rf_address  in  5  destination register.
- io_to_wb_rf_write_enabled  in  1  instruction writes the register file.
- io_to_wb_rf_write_strobe  in  4  byte lanes to write; bit i covers bits [8i+7:8i].
- read_address_0, read_address_1  in  5 each  ID read addresses.
- read_data_0, read_data_1  out  32 each  ID read data.
- wb_to_id_valid  out  1  back-pass: WB holds a valid register write.
- wb_to_id_write_register  out  5  back-pass destination register.
- trace_stall  in  1  debug trace consumer cannot accept a record.
- debug_wb_pc  out  32  PC of the retiring instruction.
- debug_wb_rf_wen  out  4  effective byte write enables.
- debug_wb_rf_wnum  out  5  destination register number.
- debug_wb_rf_wdata  out  32  raw final_result.
- retired_count  out  32  count of retired instructions.

Behaviour:
- **Reset (asynchronous, reset=0):**
  - wb_valid, all captured fields and retired_count go to 0.
  - Register file contents are not reset; registers 1..31 are undefined until written.
  - debug_wb_rf_wen=0 and wb_to_id_valid=0 while reset is asserted.
- **Handshake:**
  - wb_ready_go = ~trace_stall.
  - wb_allow_in = ~wb_valid | wb_ready_go.
  - On a rising edge with wb_allow_in=1: wb_valid <= io_to_wb_valid. If io_to_wb_valid=1, all io_to_wb_* fields are also captured; otherwise the fields hold their old values.
  - With wb_allow_in=0, all state holds.
- **Retire condition:** retire = wb_valid & wb_ready_go. Exactly one retire per accepted instruction, even if trace_stall holds for many cycles.
- **Register file write:**
  - On a clock edge when retire & we & (addr!=0), for each strobe bit i set, byte i of the register <= byte i of final_result. Unstrobed bytes keep their old value.
  - A write to register 0 is discarded.
  - A strobe of 4'b0000 writes nothing but the instruction still retires.
- **Reads:**
  - Combinational. Address 0 returns 0.
  - Write-through: if the read address equals the captured address, retire=1, we=1 and the address is non-zero, return the merged value (new bytes in strobed lanes, old bytes elsewhere) in the same cycle.
- **Debug trace:**
  - debug_wb_pc, debug_wb_rf_wnum and debug_wb_rf_wdata reflect the captured fields.
  - debug_wb_rf_wen = {4{retire & we}} & strobe. It is non-zero only in the retire cycle, and is also driven for register 0 (as in the standard trace format).
- **Back-pass:**
  - wb_to_id_valid = wb_valid & we & (addr!=0), asserted regardless of trace_stall.
  - wb_to_id_write_register = captured address.
- **retired_count:** increments by 1 on each retire edge and wraps 0xFFFFFFFF -> 0.
- **Throughput:** one instruction per cycle with no stall; one cycle latency from capture to register-file update.

Test Plan:
- Full-word write and read-back:
  - Accept we=1, addr=5, strobe=4'b1111, data=0x12345678.
  - Next cycle read_address_0=5 shows 0x12345678 via write-through, and still reads it after the edge.
  - debug_wb_rf_wen=4'b1111; retired_count=1.
- Partial lanes: with reg5=0x12345678, a strobe 4'b1100 write of data 0xAABBCCDD -> reg5=0xAABB5678. Write-through in the same cycle also returns 0xAABB5678.
- Register 0: we=1, addr=0, data=0xFFFFFFFF -> read of reg0=0; debug_wb_rf_wen=4'b1111; wb_to_id_valid=0.
- Stall:
  - Hold trace_stall=1 for 3 cycles with a valid instruction in WB -> wb_allow_in=0, no register write, debug_wb_rf_wen=0, wb_to_id_valid=1.
  - On release, exactly one write occurs and retired_count increments by 1.
- Back-to-back: 4 consecutive instructions writing regs 1..4 with values 1..4 -> 4 consecutive retire cycles, each register holds its value, retired_count=4.
- Async reset mid-stream: drop reset between clock edges while wb_valid=1 -> wb_valid, debug_wb_rf_wen and retired_count are 0 immediately (no clock edge needed), and no write occurs on the following edge.
